rotr_pipe: RTL and testbench

Parametrised, pipelined barrel rotator/shifter for the SHA-256 datapath. It replaces fixed-amount rotate wiring in places where the amount or operation is chosen at run time, such as shared sigma/Sigma evaluation and message-schedule reuse. Each operand travels through log2(WIDTH) single-bit-of-amount stages under a valid/ready handshake. A side-band tag travels with the data so results can be matched to requests.

---
 rtl/rotr_pipe.sv | 141 ++++++++++++++
 tb/tb_rotr_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotr_pipe.sv
// rotr_pipe: pipelined barrel rotator/shifter for the SHA-256 datapath.
// Operations: 00 ROTR, 01 ROTL, 10 SHR (zero fill), 11 SHL (zero fill).
// Stage k moves the operand by 2^k positions when amt[k] is set, LSB first.
// Build option ROTR_PIPE_STAGE_REG_EN: when defined, a register follows every
// stage (latency AW). When undefined, the AW stages are purely combinational
// in front of a single output register (latency 1).
// The pipe advances as a whole whenever the output slot is empty or being
// popped, and bubbles travel through it like valid beats.
module rotr_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_ROTR = 2'b00;
  localparam logic [1:0] OP_ROTL = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;

  logic advance;
  logic accept;

  // One stage: move d by sh positions under op when en is set.
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input logic             en,
                                                input int               sh);
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (op)
        OP_ROTR: r = (d >> sh) | (d << (WIDTH - sh));
        OP_ROTL: r = (d << sh) | (d >> (WIDTH - sh));
        OP_SHR:  r = d >> sh;
        default: r = d << sh;
      endcase
    end
    return r;
  endfunction

  // Global enable: the whole pipe moves unless a result is stuck at the output.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

`ifdef ROTR_PIPE_STAGE_REG_EN

  logic             vld_q  [AW];
  logic [WIDTH-1:0] data_q [AW];
  logic [1:0]       op_q   [AW];
  logic [AW-1:0]    amt_q  [AW];
  logic [TAG_W-1:0] tag_q  [AW];

  for (genvar k = 0; k < AW; k++) begin : g_stage
    logic             src_vld;
    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_op;
    logic [AW-1:0]    src_amt;
    logic [TAG_W-1:0] src_tag;

    if (k == 0) begin : g_first
      assign src_vld  = accept;
      assign src_data = in_data;
      assign src_op   = in_op;
      assign src_amt  = in_amt;
      assign src_tag  = in_tag;
    end else begin : g_next
      assign src_vld  = vld_q[k-1];
      assign src_data = data_q[k-1];
      assign src_op   = op_q[k-1];
      assign src_amt  = amt_q[k-1];
      assign src_tag  = tag_q[k-1];
    end

    // Stage k register: applies the 2^k step and forwards op/amt/tag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
        op_q[k]   <= '0;
        amt_q[k]  <= '0;
        tag_q[k]  <= '0;
      end else if (advance) begin
        vld_q[k]  <= src_vld;
        data_q[k] <= stage_fn(src_data, src_op, src_amt[k], 1 << k);
        op_q[k]   <= src_op;
        amt_q[k]  <= src_amt;
        tag_q[k]  <= src_tag;
      end
    end
  end

  assign out_valid = vld_q[AW-1];
  assign out_data  = data_q[AW-1];
  assign out_tag   = tag_q[AW-1];

`else

  logic [WIDTH-1:0] chain [AW+1];
  logic             vld_q;
  logic [WIDTH-1:0] data_q;
  logic [TAG_W-1:0] tag_q;

  assign chain[0] = in_data;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    assign chain[k+1] = stage_fn(chain[k], in_op, in_amt[k], 1 << k);
  end

  // Single output register behind the combinational stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (advance) begin
      vld_q  <= accept;
      data_q <= chain[AW];
      tag_q  <= in_tag;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;

`endif

endmodule

// File: tb/tb_rotr_pipe.sv
// Directed bench for rotr_pipe (WIDTH 32); works with either build of
// ROTR_PIPE_STAGE_REG_EN. A negedge scoreboard matches every popped result
// against a reference model in order, plus hand-computed vector checks.
module tb_rotr_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int AW    = 5;
`ifdef ROTR_PIPE_STAGE_REG_EN
  localparam int L = AW;
`else
  localparam int L = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  rotr_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          c;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] got_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  bit          chk_lat = 0;
  bit          tog_en = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] op,
                                        input logic [4:0] a);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      2'b00: begin dd = dd >> a; return dd[31:0]; end
      2'b01: begin dd = dd << a; return dd[63:32]; end
      2'b10: return d >> a;
      default: return d << a;
    endcase
  endfunction

  // cycle counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: values seen at negedge are what the next rising edge will act on
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check_val("out_without_req", out_valid, 1'b0);
        else begin
          sb_e = sb_q.pop_front();
          check_val("out_data", out_data, sb_e.d);
          check_val("out_tag", out_tag, sb_e.t);
          if (chk_lat) check_val("latency", cyc - sb_e.c, L);
          got_q.push_back(out_data);
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back('{model(in_data, in_op, in_amt), in_tag, cyc});
    end
  end

  task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                       input logic [3:0] t);
    int n = 0;
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    in_tag   = t;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_val("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain", sb_q.size(), 0);
  endtask

  initial begin
    logic [31:0] x;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 32'h0);
    check_val("rst_out_tag", out_tag, 4'h0);
    check_val("rst_in_ready", in_ready, 1'b1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic ops, back to back, with latency checked
    chk_lat = 1;
    got_q.delete();
    drive(32'h00000001, 5'd1,  2'b00, 4'h1);
    drive(32'h12345678, 5'd8,  2'b01, 4'h2);
    drive(32'h80000000, 5'd31, 2'b10, 4'h3);
    drive(32'hFFFFFFFF, 5'd4,  2'b11, 4'h4);
    wait_drain();
    check_val("basic_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_val("basic_rotr", got_q[0], 32'h80000000);
      check_val("basic_rotl", got_q[1], 32'h34567812);
      check_val("basic_shr",  got_q[2], 32'h00000001);
      check_val("basic_shl",  got_q[3], 32'hFFFFFFF0);
    end

    // amount 0 is identity for every op
    got_q.delete();
    for (int op = 0; op < 4; op++) drive(32'hDEADBEEF, 5'd0, op[1:0], op[3:0]);
    wait_drain();
    check_val("amt0_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) check_val("amt0_data", got_q[i], 32'hDEADBEEF);

    // SHA-256 Sigma0 of the first working variable
    got_q.delete();
    drive(32'h6A09E667, 5'd2,  2'b00, 4'h7);
    drive(32'h6A09E667, 5'd13, 2'b00, 4'h8);
    drive(32'h6A09E667, 5'd22, 2'b00, 4'h9);
    wait_drain();
    check_val("sigma0_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      x = got_q[0] ^ got_q[1] ^ got_q[2];
      check_val("sigma0", x, 32'hCE20B47E);
    end

    // 1000 random beats at full rate
    for (int i = 0; i < 1000; i++) begin
      drive($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
      if (i >= L - 1) check_val("full_rate_valid", out_valid, 1'b1);
    end
    wait_drain();
    chk_lat = 0;

    // backpressure: fill, freeze for 10 cycles, release
    out_ready = 1'b0;
    drive(32'hF0000000, 5'd4, 2'b00, 4'h5);
    for (int i = 1; i < L; i++)
      drive($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    in_amt   = 5'd3;
    in_op    = 2'b01;
    in_tag   = 4'h9;
    repeat (10) begin
      @(posedge clk);
      #1;
      check_val("bp_in_ready", in_ready, 1'b0);
      check_val("bp_out_valid", out_valid, 1'b1);
      check_val("bp_out_data", out_data, 32'h0F000000);
      check_val("bp_out_tag", out_tag, 4'h5);
    end
    out_ready = 1'b1;
    drive(32'hA5A5A5A5, 5'd3, 2'b01, 4'h9);
    wait_drain();

    // randomly toggling out_ready with gaps on the input side
    tog_en = 1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drive($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end
    tog_en = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // reset mid-stream, pulse not aligned to the clock
    @(posedge clk);
    #1;
    drive(32'h11111111, 5'd1, 2'b00, 4'h1);
    drive(32'h22222222, 5'd2, 2'b01, 4'h2);
    drive(32'h33333333, 5'd3, 2'b10, 4'h3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 1'b0);
    check_val("mid_rst_out_data", out_data, 32'h0);
    check_val("mid_rst_out_tag", out_tag, 4'h0);
    sb_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_in_ready", in_ready, 1'b1);
    idle(L + 5);
    check_val("post_rst_no_stale", out_valid, 1'b0);
    chk_lat = 1;
    got_q.delete();
    drive(32'h000000FF, 5'd8, 2'b00, 4'hC);
    wait_drain();
    check_val("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) check_val("post_rst_data", got_q[0], 32'hFF000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
